// File: rtl/am2948_ctrl_if.sv
// Request/enable bundle between the bus requesters and the Am2948 direction controller.
interface am2948_ctrl_if;
    logic req_tx;
    logic req_rx;
    logic tr_;
    logic rc_;
    logic gnt_tx;
    logic gnt_rx;
    logic busy;
    logic preempt;

    modport master (
        output req_tx, req_rx,
        input  tr_, rc_, gnt_tx, gnt_rx, busy, preempt
    );

    modport slave (
        input  req_tx, req_rx,
        output tr_, rc_, gnt_tx, gnt_rx, busy, preempt
    );
endinterface

// File: rtl/am2948_ctrl.sv
// Direction arbiter for an inverting bidirectional transceiver: round-robin grant,
// dead-time turnaround between grants and optional max-hold preemption.
module am2948_ctrl #(
    parameter int unsigned TURN_CYC = 1,
    parameter int unsigned MAX_HOLD = 16
) (
    input logic         clk,
    input logic         rst,
    am2948_ctrl_if.slave bus
);
    localparam int unsigned TURN_W   = $clog2(TURN_CYC + 1);
    localparam int unsigned HOLD_W   = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam int unsigned HOLD_LIM = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
    localparam bit          HOLD_EN  = (MAX_HOLD != 0);

    typedef enum logic [1:0] {IDLE, TX, RX, TURN} state_t;
    typedef enum logic {SIDE_TX, SIDE_RX} side_t;

    state_t            state, state_n, win;
    side_t             last, last_n;
    logic [HOLD_W-1:0] hold, hold_n;
    logic [TURN_W-1:0] turn, turn_n;
    logic              pre_n;
    logic              tr_q, rc_q, busy_q, pre_q;

    // Tie goes to the side that did not own the bus most recently.
    always_comb begin
        win = IDLE;
        if (bus.req_tx && (!bus.req_rx || last == SIDE_RX))
            win = TX;
        else if (bus.req_rx)
            win = RX;
    end

    always_comb begin
        state_n = state;
        last_n  = last;
        hold_n  = hold;
        turn_n  = turn;
        pre_n   = 1'b0;
        case (state)
            IDLE: begin
                state_n = win;
                hold_n  = '0;
                if (win == TX) last_n = SIDE_TX;
                if (win == RX) last_n = SIDE_RX;
            end
            TX, RX: begin
                if ((state == TX) ? !bus.req_tx : !bus.req_rx) begin
                    state_n = TURN;
                    turn_n  = TURN_W'(TURN_CYC - 1);
                end else if (((state == TX) ? bus.req_rx : bus.req_tx) && HOLD_EN &&
                             hold == HOLD_W'(HOLD_LIM)) begin
                    state_n = TURN;
                    turn_n  = TURN_W'(TURN_CYC - 1);
                    pre_n   = 1'b1;
                end else if ((state == TX) ? bus.req_rx : bus.req_tx) begin
                    if (hold != HOLD_W'(HOLD_LIM)) hold_n = hold + 1'b1;
                end else begin
                    hold_n = '0;
                end
            end
            TURN: begin
                if (turn == '0) begin
                    state_n = win;
                    hold_n  = '0;
                    if (win == TX) last_n = SIDE_TX;
                    if (win == RX) last_n = SIDE_RX;
                end else begin
                    turn_n = turn - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Enables are decoded from the next state so they leave the flops glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            last   <= SIDE_RX;
            hold   <= '0;
            turn   <= '0;
            tr_q   <= 1'b1;
            rc_q   <= 1'b1;
            busy_q <= 1'b0;
            pre_q  <= 1'b0;
        end else begin
            state  <= state_n;
            last   <= last_n;
            hold   <= hold_n;
            turn   <= turn_n;
            tr_q   <= (state_n != TX);
            rc_q   <= (state_n != RX);
            busy_q <= (state_n != IDLE);
            pre_q  <= pre_n;
        end
    end

    assign bus.tr_     = tr_q;
    assign bus.rc_     = rc_q;
    assign bus.gnt_tx  = ~tr_q;
    assign bus.gnt_rx  = ~rc_q;
    assign bus.busy    = busy_q;
    assign bus.preempt = pre_q;
endmodule

// File: doc/am2948_ctrl.md
Name: am2948_ctrl

Overview:
- Synchronous direction controller/arbiter for an inverting bidirectional bus transceiver. The transceiver has active-low enables: tr_ drives A->B, rc_ drives B->A.
- Arbitrates between an A-side requester (transmit) and a B-side requester (receive).
- Inserts a dead-time turnaround between direction changes and enforces a maximum hold time, so tr_ and rc_ are never low together.

Parameters:
- TURN_CYC, 1: turnaround dead cycles with both enables high after each release; legal range >=1.
- MAX_HOLD, 16: max consecutive granted cycles while the opposite side is requesting; 0 = unlimited (no preemption).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- req_tx  input  1  A-side requests A->B drive; held high while bus wanted
- req_rx  input  1  B-side requests B->A drive; held high while bus wanted
- tr_  output  1  transceiver transmit enable, active-low, registered
- rc_  output  1  transceiver receive enable, active-low, registered
- gnt_tx  output  1  A-side owns bus; equals ~tr_
- gnt_rx  output  1  B-side owns bus; equals ~rc_
- busy  output  1  high in TX, RX or TURN
- preempt  output  1  one-cycle pulse on the edge that forces a release due to MAX_HOLD

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE; tr_=1, rc_=1; gnt_tx=0, gnt_rx=0; busy=0; preempt=0.
  - last=RX, so TX wins the first tie.
  - Hold and turn counters cleared.
  - Reset mid-grant drops the grant at that edge with no turnaround. Bus is disabled from that edge on.
- States: IDLE, TX, RX, TURN. All outputs are registered decodes of state: TX -> tr_=0; RX -> rc_=0; otherwise both 1.
- Arbitration applies in IDLE, and in TURN on its final cycle:
  - Only req_tx -> TX.
  - Only req_rx -> RX.
  - Both -> the side != last.
  - Neither -> IDLE.
  - On entering TX/RX: set last to that side; clear hold counter.
- Latency:
  - Request sampled high in IDLE at edge n -> grant/enable low after edge n (1 cycle).
  - No dead time from IDLE; IDLE is only entered from reset or after TURN.
- TX (RX symmetric):
  - req_tx low at edge -> TURN; tr_ high after that edge.
  - Preemption: MAX_HOLD!=0, hold counter==MAX_HOLD-1, and req_rx high at edge -> TURN; preempt pulses high for the following cycle.
  - Otherwise stay in TX. The hold counter increments while the opposite request is high, saturates at MAX_HOLD-1, and clears when the opposite request is low.
- TURN:
  - Turn counter loads TURN_CYC-1 on entry and decrements each cycle.
  - At 0, arbitrate as above, going directly to TX/RX or IDLE.
  - Requests arriving during TURN are not granted before TURN completes.
- Preempted side:
  - Keeps req high and is re-granted after the other side releases or is preempted.
  - Round-robin via last guarantees alternation under continuous contention.
- Invariants:
  - tr_ and rc_ are never both 0.
  - Between any tr_ low period and any rc_ low period there are at least TURN_CYC cycles with both high.
  - The bench checks this every cycle.
- Widths:
  - Turn counter width = clog2(TURN_CYC+1).
  - Hold counter width = clog2(MAX_HOLD+1), min 1.
  - No wrap; counters saturate.
- A requester dropping and re-raising req within TX still passes through TURN. No same-side back-to-back without dead time.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, requests 0 -> tr_=1, rc_=1, gnt_*=0, busy=0 for 10 cycles.
- Single TX transfer (TURN_CYC=2): req_tx high at edge 3 for 5 cycles -> tr_=0 after edges 3..7. tr_=1 after edge 8. Both high for exactly 2 cycles. busy=1 through TURN, then 0.
- Simultaneous requests after reset: req_tx=req_rx=1 at edge 2 -> TX granted first. After req_tx drops and TURN_CYC=1 cycle, RX granted. rc_ never low while tr_ low.
- Preemption (MAX_HOLD=4, TURN_CYC=1): TX granted, req_rx raised same cycle and both held -> tr_ low exactly 4 cycles, preempt pulse, 1 dead cycle, rc_ low 4 cycles, then TX again. Alternation repeats for 3 rounds.
- MAX_HOLD=0: both requests held 50 cycles -> TX holds all 50, preempt never pulses.
- Reset mid-grant: rst asserted while rc_=0 -> rc_=1 after that edge, state IDLE. req_tx pending at release -> tr_=0 one edge after rst deasserts.
